// File: rtl/detector_stream_arbiter.sv
// Arbiter/sequencer feeding one WIDTH-bit word MSB-first into a serial detector.
// Define DSA_ROUND_ROBIN_EN for round-robin arbitration; default is fixed priority.
module detector_stream_arbiter #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic [WIDTH-1:0] data0,
  output logic             grant0,
  input  logic             req1,
  input  logic [WIDTH-1:0] data1,
  output logic             grant1,
  output logic             det_clr,
  output logic             w,
  input  logic             z,
  output logic             busy,
  output logic             done,
  output logic             owner,
  output logic [CNT_W-1:0] hit_count
);

  localparam int BW = $clog2(WIDTH);
  localparam logic [BW-1:0] LAST = BW'(WIDTH - 1);
  localparam logic [CNT_W-1:0] HMAX = '1;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    SHIFT,
    DONE
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] sr;
  logic [BW-1:0]    bitcnt;
  logic [CNT_W-1:0] hits;
  logic             win;
  logic             take;
  logic             sample;

`ifdef DSA_ROUND_ROBIN_EN
  logic prio;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prio <= 1'b0;
    end else if (take) begin
      prio <= ~win;
    end
  end

  assign win = (req0 & req1) ? prio : req1;
`else
  assign win = ~req0;
`endif

  // reset gates the grant decode so no grant is seen while held in reset
  assign take   = reset & (state == IDLE) & (req0 | req1);
  assign grant0 = take & ~win;
  assign grant1 = take & win;

  // z lags w by one bit: skip k=0, include the DONE cycle
  assign sample = ((state == SHIFT) && (bitcnt != '0))
                | (state == DONE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    det_clr  = 1'b0;
    w        = 1'b0;
    busy     = 1'b1;
    done     = 1'b0;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (take) state_nx = CLEAR;
      end
      CLEAR: begin
        det_clr  = 1'b1;
        state_nx = SHIFT;
      end
      SHIFT: begin
        w = sr[WIDTH-1];
        if (bitcnt == LAST) state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr     <= '0;
      bitcnt <= '0;
      owner  <= 1'b0;
      hits   <= '0;
    end else begin
      if (take) begin
        sr     <= win ? data1 : data0;
        owner  <= win;
        hits   <= '0;
        bitcnt <= '0;
      end
      if (state == SHIFT) begin
        sr     <= {sr[WIDTH-2:0], 1'b0};
        bitcnt <= bitcnt + 1'b1;
      end
      if (sample && z && (hits != HMAX)) begin
        hits <= hits + 1'b1;
      end
    end
  end

  assign hit_count = hits;

endmodule

// File: tb/tb_detector_stream_arbiter.sv
// Bench for detector_stream_arbiter: "110" detector model plus transfer-level
// reference model; honours DSA_ROUND_ROBIN_EN like the design.
module tb_detector_stream_arbiter;

  localparam int W    = 8;
  localparam int CW   = 2;
  localparam int HMAX = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          req0 = 1'b0;
  logic          req1 = 1'b0;
  logic [W-1:0]  data0 = '0;
  logic [W-1:0]  data1 = '0;
  logic          grant0, grant1, det_clr, w, z;
  logic          busy, done, owner;
  logic [CW-1:0] hit_count;

  int n_chk  = 0;
  int n_fail = 0;
  bit force_z = 1'b0;

  always #5 clk = ~clk;

  detector_stream_arbiter #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .data0(data0), .grant0(grant0),
    .req1(req1), .data1(data1), .grant1(grant1),
    .det_clr(det_clr), .w(w), .z(z),
    .busy(busy), .done(done),
    .owner(owner), .hit_count(hit_count)
  );

  logic [2:0] hist;
  int         nv;

  always @(posedge clk or negedge reset) begin
    if (!reset || det_clr) begin
      hist <= '0;
      nv   <= 0;
    end else begin
      hist <= {hist[1:0], w};
      if (nv < 3) nv <= nv + 1;
    end
  end

  assign z = force_z | ((nv >= 3) && (hist == 3'b110));

  task automatic check(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  // after bit j (MSB first) the detector reports z if bits j-2..j are 1,1,0
  function automatic int exp_hits(input logic [W-1:0] wd, input bit fz);
    int n = 0;
    for (int j = 0; j < W; j++) begin
      if (fz) n++;
      else if (j >= 2 && wd[W+1-j] && wd[W-j] && !wd[W-1-j]) n++;
    end
    return (n > HMAX) ? HMAX : n;
  endfunction

  int           mt = 0;
  bit           m_owner = 0;
  bit           m_prio = 0;
  bit           m_win;
  bit           m_gv;
  int           m_final = 0;
  logic [W-1:0] m_word = '0;

  // mt: 0 idle, 1 clear, 2..W+1 shifting, W+2 done
  always @(negedge clk) begin
    if (!reset) begin
      check("rst_grant", {grant1, grant0}, 0);
      check("rst_busy", busy, 0);
      check("rst_w", w, 0);
      check("rst_clr", det_clr, 0);
      check("rst_done", done, 0);
      check("rst_owner", owner, 0);
      check("rst_hits", hit_count, 0);
      mt = 0; m_owner = 0; m_prio = 0; m_final = 0;
    end else begin
      m_gv = (mt == 0) && (req0 || req1);
`ifdef DSA_ROUND_ROBIN_EN
      m_win = (req0 && req1) ? m_prio : req1;
`else
      m_win = !req0;
`endif
      check("grant0", grant0, m_gv && !m_win);
      check("grant1", grant1, m_gv && m_win);
      check("busy", busy, mt != 0);
      check("det_clr", det_clr, mt == 1);
      check("w", w, (mt >= 2 && mt <= W + 1) ? m_word[W+1-mt] : 1'b0);
      check("done", done, mt == W + 2);
      check("owner", owner, m_owner);
      if (mt == 0) check("hits", hit_count, m_final);
      else if (mt == 1) check("hits_clr", hit_count, 0);
      if (m_gv) begin
        mt      = 1;
        m_owner = m_win;
        m_prio  = !m_win;
        m_word  = m_win ? data1 : data0;
        m_final = exp_hits(m_word, force_z);
      end else if (mt == W + 2) mt = 0;
      else if (mt != 0) mt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(input bit who, output int n);
    bit got = 0;
    n = 0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      n++;
      if (who ? grant1 : grant0) got = 1;
    end
    check("grant_timeout", got, 1);
  endtask

  task automatic send(input bit who, input logic [W-1:0] d);
    int n;
    if (who) begin data1 = d; req1 = 1; end
    else begin data0 = d; req0 = 1; end
    wait_grant(who, n);
    tick();
    if (who) req1 = 0;
    else req0 = 0;
  endtask

  task automatic wait_idle();
    bit idle = 0;
    for (int i = 0; i < 40 && !idle; i++) begin
      @(negedge clk);
      if (!busy) idle = 1;
    end
    check("idle_timeout", idle, 1);
    tick();
  endtask

  initial begin
    int n;
    bit g0, g1;
    bit seq[$];

    req0 = 1; data0 = 8'hA5;
    repeat (3) @(posedge clk);
    #1 reset = 1;
    @(negedge clk);
    check("grant_after_rst", grant0, 1);
    tick();
    req0 = 0;
    wait_idle();

    send(0, 8'b1101_1000);
    wait_idle();
    check("hits_110", hit_count, 2);
    check("owner_110", owner, 0);

    force_z = 1;
    send(1, W'($urandom));
    wait_idle();
    check("hits_sat", hit_count, HMAX);
    check("owner_sat", owner, 1);
    force_z = 0;

    data0 = W'($urandom); data1 = W'($urandom);
    req0 = 1; req1 = 1;
    for (int i = 0; i < 4 * (W + 3); i++) begin
      @(negedge clk);
      if (grant0) seq.push_back(1'b0);
      if (grant1) seq.push_back(1'b1);
    end
    tick();
    req0 = 0; req1 = 0;
    check("tie_count", seq.size(), 4);
    foreach (seq[i]) begin
`ifdef DSA_ROUND_ROBIN_EN
      check("tie_seq", seq[i], i % 2);
`else
      check("tie_seq", seq[i], 0);
`endif
    end
    wait_idle();

    data0 = W'($urandom); req0 = 1;
    wait_grant(0, n);
    tick();
    req0 = 0;
    repeat (4) tick();
    data1 = W'($urandom); req1 = 1;
    wait_grant(1, n);
    check("busy_req_lat", n, W - 1);
    tick();
    req1 = 0;
    wait_idle();

    data0 = 8'b1101_1000; req0 = 1;
    wait_grant(0, n);
    tick();
    req0 = 0;
    data1 = W'($urandom); req1 = 1;
    repeat (4) tick();
    check("pre_busy", busy, 1);
    check("pre_w", w, 1);
    reset = 0;
    #1;
    check("async_busy", busy, 0);
    check("async_w", w, 0);
    check("async_hits", hit_count, 0);
    check("async_done", done, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1;
    wait_grant(1, n);
    check("post_rst_lat", n, 1);
    tick();
    req1 = 0;
    wait_idle();
    check("post_rst_owner", owner, 1);

    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      g0 = grant0; g1 = grant1;
      tick();
      if (g0) begin req0 = 0; data0 = W'($urandom); end
      else if (!req0 && $urandom_range(3) == 0) begin
        data0 = W'($urandom); req0 = 1;
      end
      if (g1) begin req1 = 0; data1 = W'($urandom); end
      else if (!req1 && $urandom_range(3) == 0) begin
        data1 = W'($urandom); req1 = 1;
      end
    end
    req0 = 0; req1 = 0;
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/detector_stream_arbiter.md
# detector_stream_arbiter

Arbitration and sequencing controller for the serial pattern-detector FSM (single-bit input `w`, Moore output `z`). Two requesters each submit a WIDTH-bit word; the block grants one, clears the detector, shifts the word into `w` MSB first, and counts the `z` hits produced by that word. The block sits between the requesting logic and the detector instance and is the only driver of the detector's `w` input and clear.

## Interface
- `WIDTH`, 8: bits per submitted word; legal range 2..32.
- `CNT_W`, 4: width of the hit counter.

- `clk`  in  1  system clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req0`  in  1  requester 0 wants a transfer; held until `grant0`.
- `data0`  in  WIDTH  requester 0 word; stable while `req0` is high.
- `grant0`  out  1  one-cycle pulse: `data0` is captured at this edge.
- `req1`  in  1  requester 1 request.
- `data1`  in  WIDTH  requester 1 word.
- `grant1`  out  1  one-cycle grant pulse for requester 1.
- `det_clr`  out  1  active-high synchronous clear to the detector.
- `w`  out  1  serial bit into the detector.
- `z`  in  1  detector Moore output.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse when a word's count is final.
- `owner`  out  1  index of the requester served by the current/last transfer.
- `hit_count`  out  CNT_W  number of `z` hits for the current/last word.

## Operation
- States: IDLE, CLEAR, SHIFT, DONE. Reset state IDLE.
- IDLE: if `req0` or `req1`, choose winner (see Configuration), pulse that grant, capture its data into shift register, set `owner`, clear `hit_count`, clear bit counter, go CLEAR. No request: stay.
- CLEAR (1 cycle): `det_clr`=1, `w`=0. Go SHIFT.
- SHIFT (WIDTH cycles, k=0..WIDTH-1): `w` = shift register MSB = bit WIDTH-1-k of the captured word; shift left each cycle. After k=WIDTH-1 go DONE.
- DONE (1 cycle): `done`=1, `w`=0. Go IDLE.
- Hit sampling: `z` reflects the detector state after the previous bit, so `z` is sampled in SHIFT cycles k=1..WIDTH-1 and in the DONE cycle (exactly WIDTH samples). `z` during CLEAR and SHIFT k=0 is ignored.
- `hit_count` increments by 1 per sampled `z`=1, saturating at 2^CNT_W-1; the DONE-cycle sample is included in the value present after the DONE edge. Holds until next grant.
- Requests arriving while busy are not granted; they wait until IDLE. A request still high after its own transfer is a new request.
- `owner` and `hit_count` reset to 0; `data*` changes after grant have no effect.

## Timing
- Reset values: `grant0`=`grant1`=0, `det_clr`=0, `w`=0, `busy`=0, `done`=0, `owner`=0, `hit_count`=0, round-robin pointer = requester 0 preferred.
- Reset asserted mid-transfer: immediate return to IDLE with all outputs at reset values; partial transfer is discarded, no `done`.
- Grant to first data bit on `w`: 2 cycles (grant cycle, CLEAR). Grant to `done`: WIDTH+2 cycles. Back-to-back transfers: next grant no earlier than the cycle after `done` (period WIDTH+3).
- All outputs are registered or decoded from registered state only; no combinational path from `z` or `req*` to any output except `grant*` (decoded in IDLE from `req*`).

## Configuration
- `DSA_ROUND_ROBIN_EN` defined: round-robin; when both request in IDLE, grant the requester not served last; pointer updates on every grant. Single requester always wins.
- Undefined: fixed priority; `req0` always wins a tie; pointer logic absent.

## Test plan
- Reset: hold `reset`=0 three cycles with `req0`=1 -> all outputs 0, no grant; release -> `grant0` pulse next cycle.
- Single transfer, WIDTH=8, detector model asserting `z` after bits "110": `data0`=8'b1101_1000 -> `grant0` one cycle, `det_clr` next cycle, `w` sequence 1,1,0,1,1,0,0,0, `done` 10 cycles after grant, `hit_count`=2, `owner`=0.
- Tie: `req0`=`req1`=1 held continuously -> with `DSA_ROUND_ROBIN_EN`, grants alternate 0,1,0,1 at 11-cycle spacing; without it, only `grant0`.
- Saturation: CNT_W=2, `z` forced 1 throughout -> `hit_count` stops at 3, `done` still at WIDTH+2.
- Reset mid-SHIFT (k=3): `busy`, `w`, `hit_count` go 0 asynchronously, no `done`; after release, pending `req1` granted normally.
- Request during busy: `req1` raised in SHIFT -> no `grant1` until cycle after `done`.
